// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiply/divide unit for the execute stage.
//   Multiply uses radix-4 Booth recoding and takes WIDTH/2 iterations.
//   Divide uses non-restoring division on magnitudes, takes WIDTH iterations,
//   and fixes the sign of the quotient at the end.
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-high reset
//   data_operandA/B       - operands, sampled only on a start edge
//   ctrl_MULT / ctrl_DIV  - start pulses (MULT wins when both are high)
//   ctrl_flush            - abort in-flight operation (beats a simultaneous start)
//   data_result           - product low bits or quotient (held until next start)
//   data_exception        - overflow / divide-by-zero flag for the completed op
//   data_resultRDY        - one-cycle completion strobe
//   busy                  - high while iterating (MUL or DIV)
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_flush,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH / 2 - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    // {upper partial sum (WIDTH+2), remaining multiplier bits (WIDTH)}
    logic [2*WIDTH+1:0]   acc_q, acc_d;
    logic                 booth_q;
    logic [WIDTH+1:0]     mcand_q;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvsr_q;
    logic                 neg_q;
    logic [WIDTH-1:0]     result_q;
    logic                 exc_q;
    logic                 rdy_q;
    logic                 busy_q;

    logic [WIDTH+1:0]     addend_s;
    logic [WIDTH+1:0]     hi_sum_s;
    logic [WIDTH:0]       mul_hi_s;
    logic                 mul_ovf_s;
    logic [WIDTH:0]       rem_shift_s;
    logic [WIDTH-1:0]     div_res_s;
    logic                 div_ovf_s;
    logic [WIDTH-1:0]     abs_a_s;
    logic [WIDTH-1:0]     abs_b_s;
    logic                 start_s;

    assign start_s        = ctrl_MULT | ctrl_DIV;
    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

    // Booth digit selection, partial-sum add and 2-bit arithmetic shift.
    always_comb begin
        addend_s = '0;
        case ({acc_q[1:0], booth_q})
            3'b001, 3'b010: addend_s = mcand_q;
            3'b011:         addend_s = {mcand_q[WIDTH:0], 1'b0};
            3'b100:         addend_s = -{mcand_q[WIDTH:0], 1'b0};
            3'b101, 3'b110: addend_s = -mcand_q;
            default:        addend_s = '0;
        endcase
        hi_sum_s  = acc_q[2*WIDTH+1:WIDTH] + addend_s;
        acc_d     = {{2{hi_sum_s[WIDTH+1]}}, hi_sum_s, acc_q[WIDTH-1:2]};
        // Product fits in WIDTH signed bits only if bits [2W-1:W-1] agree.
        mul_hi_s  = acc_d[2*WIDTH-1:WIDTH-1];
        mul_ovf_s = ~((&mul_hi_s) | ~(|mul_hi_s));
    end

    // Non-restoring divide step plus final sign correction of the quotient.
    always_comb begin
        rem_shift_s = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        if (rem_q[WIDTH]) begin
            rem_d = rem_shift_s + {1'b0, dvsr_q};
        end else begin
            rem_d = rem_shift_s - {1'b0, dvsr_q};
        end
        quo_d = {quo_q[WIDTH-2:0], ~rem_d[WIDTH]};
        if (neg_q) begin
            div_res_s = -quo_d;
        end else begin
            div_res_s = quo_d;
        end
        // A non-negative quotient with the top bit set only arises from MIN / -1.
        div_ovf_s = ~neg_q & quo_d[WIDTH-1];
    end

    // Operand magnitudes for the divider (MIN maps to 2^(WIDTH-1) unsigned).
    always_comb begin
        if (data_operandA[WIDTH-1]) begin
            abs_a_s = -data_operandA;
        end else begin
            abs_a_s = data_operandA;
        end
        if (data_operandB[WIDTH-1]) begin
            abs_b_s = -data_operandB;
        end else begin
            abs_b_s = data_operandB;
        end
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            booth_q  <= 1'b0;
            mcand_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else if (ctrl_flush) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else if (start_s) begin
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            if (ctrl_MULT) begin
                state_q <= S_MUL;
                busy_q  <= 1'b1;
                acc_q   <= {{(WIDTH+2){1'b0}}, data_operandB};
                booth_q <= 1'b0;
                mcand_q <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
            end else if (data_operandB != '0) begin
                state_q <= S_DIV;
                busy_q  <= 1'b1;
                rem_q   <= '0;
                quo_q   <= abs_a_s;
                dvsr_q  <= abs_b_s;
                neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            end else begin
                // Divide by zero completes on the start edge itself.
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                exc_q   <= 1'b1;
                rdy_q   <= 1'b1;
            end
        end else begin
            case (state_q)
                S_MUL: begin
                    acc_q   <= acc_d;
                    booth_q <= acc_q[1];
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == MUL_LAST) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        rdy_q    <= 1'b1;
                        result_q <= acc_d[WIDTH-1:0];
                        exc_q    <= mul_ovf_s;
                    end else begin
                        state_q <= S_MUL;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == DIV_LAST) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        rdy_q    <= 1'b1;
                        result_q <= div_res_s;
                        exc_q    <= div_ovf_s;
                    end else begin
                        state_q <= S_DIV;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    rdy_q   <= 1'b0;
                end
                S_IDLE: begin
                    rdy_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    rdy_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit (WIDTH=32): directed cases for the
// arithmetic boundaries and abort paths, then random operations compared
// against a plain-arithmetic reference model.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic        ctrl_flush = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int total = 0;
    int bad = 0;
    int rdy_cnt = 0;

    logic [31:0] exp_res;
    logic        exp_exc;
    int          exp_lat;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .ctrl_flush     (ctrl_flush),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Count every RDY strobe, sampled mid-cycle.
    always @(negedge clock) begin
        if (data_resultRDY === 1'b1) rdy_cnt++;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain signed arithmetic.
    task automatic model(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] pa, pb, pp;
        int ai, bi;
        if (is_mul) begin
            pa = {{32{a[31]}}, a};
            pb = {{32{b[31]}}, b};
            pp = pa * pb;
            exp_res = pp[31:0];
            exp_exc = (pp != {{32{pp[31]}}, pp[31:0]});
            exp_lat = 16;
        end else if (b == 32'd0) begin
            exp_res = 32'd0;
            exp_exc = 1'b1;
            exp_lat = 0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            exp_res = 32'h8000_0000;
            exp_exc = 1'b1;
            exp_lat = 32;
        end else begin
            ai = a;
            bi = b;
            exp_res = ai / bi;
            exp_exc = 1'b0;
            exp_lat = 32;
        end
    endtask

    // Drive a start pulse; caller is positioned between edges. Returns just after E0.
    task automatic start_op(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
        model(is_mul, a, b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = is_mul;
        ctrl_DIV  = ~is_mul;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Wait for RDY (bounded), check latency, busy, result; optionally the cycle after.
    task automatic finish_op(input string tag, input bit tail);
        int  k = 0;
        bit  busy_ok = 1'b1;
        while (data_resultRDY !== 1'b1 && k < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clock);
            #1;
            k++;
        end
        check_val({tag, " latency"}, 64'(k), 64'(exp_lat));
        check_val({tag, " busy_during"}, 64'(busy_ok), 64'd1);
        check_val({tag, " busy_at_rdy"}, 64'(busy), 64'd0);
        check_val({tag, " result"}, 64'(data_result), 64'(exp_res));
        check_val({tag, " exception"}, 64'(data_exception), 64'(exp_exc));
        if (tail) begin
            @(posedge clock);
            #1;
            check_val({tag, " rdy_one_cycle"}, 64'(data_resultRDY), 64'd0);
            check_val({tag, " result_hold"}, {31'd0, data_exception, data_result},
                      {31'd0, exp_exc, exp_res});
        end
    endtask

    task automatic run_op(input string tag, input bit is_mul, input logic [31:0] a, input logic [31:0] b);
        start_op(is_mul, a, b);
        finish_op(tag, 1'b1);
    endtask

    initial begin
        int snap;
        logic [31:0] ra, rb;
        bit rm;

        repeat (2) @(posedge clock);
        #1;
        check_val("reset_state", {29'd0, data_exception, data_resultRDY, busy, data_result}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Directed arithmetic cases.
        run_op("mul_7x-3",   1'b1, 32'd7, 32'hFFFF_FFFD);
        run_op("mul_ovf",    1'b1, 32'h0001_0000, 32'h0001_0000);
        run_op("mul_min",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_-7/2",   1'b0, 32'hFFFF_FFF9, 32'd2);
        run_op("div_ovf",    1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_zero",   1'b0, 32'd5, 32'd0);
        run_op("div_min/1",  1'b0, 32'h8000_0000, 32'd1);
        run_op("mul_maxsq",  1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);

        // Back-to-back: start on the edge that leaves DONE.
        start_op(1'b1, 32'd7, 32'hFFFF_FFFD);
        finish_op("b2b_first", 1'b0);
        start_op(1'b0, 32'hFFFF_FFF9, 32'd2);
        finish_op("b2b_second", 1'b1);

        // Abort a divide with a multiply at E10.
        snap = rdy_cnt;
        start_op(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clock);
        #1;
        start_op(1'b1, 32'd3, 32'd4);
        finish_op("abort_mul", 1'b0);
        repeat (40) @(posedge clock);
        #1;
        check_val("abort_one_rdy", 64'(rdy_cnt - snap), 64'd1);

        // Flush at E5 of a multiply.
        snap = rdy_cnt;
        start_op(1'b1, 32'd5, 32'd6);
        repeat (4) @(posedge clock);
        #1;
        ctrl_flush = 1'b1;
        @(posedge clock);
        #1;
        ctrl_flush = 1'b0;
        check_val("flush_busy", 64'(busy), 64'd0);
        repeat (30) @(posedge clock);
        #1;
        check_val("flush_no_rdy", 64'(rdy_cnt - snap), 64'd0);

        // Flush beats a simultaneous start.
        snap = rdy_cnt;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        ctrl_MULT = 1'b1;
        ctrl_flush = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_flush = 1'b0;
        check_val("flush_vs_start_busy", 64'(busy), 64'd0);
        repeat (25) @(posedge clock);
        #1;
        check_val("flush_vs_start_rdy", 64'(rdy_cnt - snap), 64'd0);

        // Asynchronous reset mid-operation.
        run_op("pre_reset", 1'b1, 32'd1234, 32'd5678);
        start_op(1'b1, 32'h1234_5678, 32'h0765_4321);
        repeat (7) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check_val("async_reset", {29'd0, data_exception, data_resultRDY, busy, data_result}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        snap = rdy_cnt;
        repeat (25) @(posedge clock);
        #1;
        check_val("post_reset_no_rdy", 64'(rdy_cnt - snap), 64'd0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rm = 1'($urandom_range(0, 1));
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = 32'($signed($urandom_range(0, 16)) - 8);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = {16'd0, 16'($urandom)};
            endcase
            if ($urandom_range(0, 9) == 0) rb = 32'd0;
            run_op($sformatf("rand%0d_%s", i, rm ? "mul" : "div"), rm, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
